// File: rtl/tlul_host_adapter.sv
// TL-UL host adapter: turns a req/gnt core memory port into TL-UL A-channel requests and
// returns in-order D-channel responses as rvalid/rdata/err.
package tlul_pkg;
  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [7:0]  d_source;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module tlul_host_adapter
  import tlul_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter logic [7:0]  SourceBase     = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output tl_h2d_t     tl_h_o,
  input  tl_d2h_t     tl_h_i
);
  localparam int unsigned IdxW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(MaxOutstanding - 1);

  typedef enum logic {EMPTY, PENDING} a_state_e;

  a_state_e        state, state_next;
  logic [IdxW-1:0] wr_idx, rd_idx;
  logic [CntW-1:0] inflight;
  logic [7:0]      fifo_src [MaxOutstanding];
  logic            fifo_we  [MaxOutstanding];

  logic [2:0]  a_opcode_q;
  logic [7:0]  a_source_q;
  logic [31:0] a_address_q;
  logic [3:0]  a_mask_q;
  logic [31:0] a_data_q;

  logic       d_hs, fifo_nonempty, pop;
  logic [7:0] head_src;
  logic       head_we;

  function automatic logic [IdxW-1:0] idx_inc(input logic [IdxW-1:0] i);
    return (i == LastIdx) ? '0 : i + 1'b1;
  endfunction

  assign gnt_o = req_i & ((state == EMPTY) | tl_h_i.a_ready) & (inflight < MaxCnt);

  assign d_hs          = tl_h_i.d_valid;
  assign fifo_nonempty = (inflight != '0);
  assign pop           = d_hs & fifo_nonempty;
  assign head_src      = fifo_src[rd_idx];
  assign head_we       = fifo_we[rd_idx];

  always_ff @(posedge clock) begin
    if (!reset) state <= EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (gnt_o) state_next = PENDING;
      PENDING: if (tl_h_i.a_ready && !gnt_o) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    tl_h_o           = '0;
    tl_h_o.a_valid   = (state == PENDING);
    tl_h_o.a_opcode  = a_opcode_q;
    tl_h_o.a_param   = '0;
    tl_h_o.a_size    = 2'd2;
    tl_h_o.a_source  = a_source_q;
    tl_h_o.a_address = a_address_q;
    tl_h_o.a_mask    = a_mask_q;
    tl_h_o.a_data    = a_data_q;
    tl_h_o.d_ready   = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      a_opcode_q  <= Get;
      a_source_q  <= '0;
      a_address_q <= '0;
      a_mask_q    <= '0;
      a_data_q    <= '0;
    end else if (gnt_o) begin
      a_opcode_q  <= !we_i ? Get : ((be_i == 4'hF) ? PutFullData : PutPartialData);
      a_source_q  <= SourceBase | 8'(wr_idx);
      a_address_q <= addr_i & ~32'h3;
      a_mask_q    <= we_i ? be_i : 4'hF;
      a_data_q    <= we_i ? wdata_i : '0;
    end
  end

  // The order-FIFO write pointer doubles as the issue index: both start at 0 and step on gnt.
  always_ff @(posedge clock) begin
    if (gnt_o) begin
      fifo_src[wr_idx] <= SourceBase | 8'(wr_idx);
      fifo_we[wr_idx]  <= we_i;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      inflight <= '0;
    end else begin
      if (gnt_o) wr_idx <= idx_inc(wr_idx);
      if (pop)   rd_idx <= idx_inc(rd_idx);
      case ({gnt_o, pop})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= d_hs;
      rdata_o  <= '0;
      err_o    <= 1'b0;
      if (d_hs) begin
        if (fifo_nonempty) begin
          rdata_o <= head_we ? '0 : tl_h_i.d_data;
          err_o   <= tl_h_i.d_error | (tl_h_i.d_source != head_src) |
                     (tl_h_i.d_opcode != (head_we ? AccessAck : AccessAckData));
        end else begin
          err_o <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_tlul_host_adapter.sv
// Bench for tlul_host_adapter: directed protocol scenarios followed by a randomized run
// checked against a queue-based model of grants, A-channel issue and in-order responses.
module tb_tlul_host_adapter;
  import tlul_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req, gnt, we, rvalid, err;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  tl_h2d_t     h2d;
  tl_d2h_t     d2h;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  tlul_host_adapter #(.MaxOutstanding(4), .SourceBase(8'h00)) dut (
    .clock(clock), .reset(reset), .req_i(req), .gnt_o(gnt), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .tl_h_o(h2d), .tl_h_i(d2h)
  );

  typedef struct {
    logic        w;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [3:0]  b;
    logic [7:0]  src;
  } txn_t;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Expected A-channel fields {opcode, param, size, source, address, mask, data}.
  function automatic logic [83:0] a_exp(input logic w, input logic [31:0] ad,
                                        input logic [31:0] wd, input logic [3:0] b,
                                        input logic [7:0] src);
    logic [2:0]  op;
    logic [31:0] al;
    op = !w ? 3'd4 : ((b == 4'hF) ? 3'd0 : 3'd1);
    al = {ad[31:2], 2'b00};
    return {op, 3'd0, 2'd2, src, al, w ? b : 4'hF, w ? wd : 32'd0};
  endfunction

  function automatic logic [83:0] a_obs();
    return {h2d.a_opcode, h2d.a_param, h2d.a_size, h2d.a_source, h2d.a_address,
            h2d.a_mask, h2d.a_data};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic d_resp(input logic [7:0] src, input logic [2:0] op, input logic [31:0] data,
                        input logic e);
    d2h.d_valid  = 1'b1;
    d2h.d_source = src;
    d2h.d_opcode = op;
    d2h.d_data   = data;
    d2h.d_error  = e;
  endtask

  task automatic d_idle();
    d2h.d_valid  = 1'b0;
    d2h.d_source = '0;
    d2h.d_opcode = '0;
    d2h.d_data   = '0;
    d2h.d_error  = 1'b0;
  endtask

  txn_t        aq[$];
  txn_t        devq[$];
  txn_t        t;
  int          out_cnt;
  logic [7:0]  next_src;
  logic        g_s, hsa_s, hsd_s, de, hold, g_exp;
  logic [31:0] dd;

  initial begin
    req = 0; we = 0; addr = '0; wdata = '0; be = '0;
    d2h = '0; d2h.a_ready = 1'b1;
    d_idle();

    // Reset state
    reset = 0;
    repeat (3) tick();
    chk("rst_a_valid", h2d.a_valid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_d_ready", h2d.d_ready, 1);
    reset = 1;
    tick();

    // Single read, source 0
    req = 1; we = 0; addr = 32'h1000_0004;
    #1 chk("t1_gnt", gnt, 1);
    tick(); req = 0;
    chk("t1_a_valid", h2d.a_valid, 1);
    chk("t1_a_fields", a_obs(), a_exp(0, 32'h1000_0004, 0, 0, 8'd0));
    d_resp(8'd0, AccessAckData, 32'hDEAD_BEEF, 0);
    tick(); d_idle();
    chk("t1_a_done", h2d.a_valid, 0);
    chk("t1_rvalid", rvalid, 1);
    chk("t1_rdata", rdata, 32'hDEAD_BEEF);
    chk("t1_err", err, 0);
    tick();
    chk("t1_rvalid_pulse", rvalid, 0);

    // Partial write, source 1
    req = 1; we = 1; be = 4'b0011; wdata = 32'h1234_5678; addr = 32'h2000_000B;
    #1 chk("t2_gnt", gnt, 1);
    tick(); req = 0; we = 0;
    chk("t2_a_fields", a_obs(), a_exp(1, 32'h2000_000B, 32'h1234_5678, 4'b0011, 8'd1));
    d_resp(8'd1, AccessAck, 32'hFFFF_FFFF, 0);
    tick(); d_idle();
    chk("t2_rvalid", rvalid, 1);
    chk("t2_rdata", rdata, 0);
    chk("t2_err", err, 0);

    // Backpressure: fields frozen, second request blocked
    d2h.a_ready = 0; req = 1; we = 0; addr = 32'h3000_000C;
    #1 chk("t3_gnt_first", gnt, 1);
    tick();
    we = 1; addr = 32'h4000_0010; wdata = 32'hA5A5_A5A5; be = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_gnt_blocked", gnt, 0);
      chk("t3_a_valid", h2d.a_valid, 1);
      chk("t3_a_stable", a_obs(), a_exp(0, 32'h3000_000C, 0, 0, 8'd2));
      tick();
    end
    d2h.a_ready = 1;
    #1 chk("t3_gnt_release", gnt, 1);
    tick(); req = 0; we = 0;
    chk("t3_a_second", a_obs(), a_exp(1, 32'h4000_0010, 32'hA5A5_A5A5, 4'hF, 8'd3));
    d_resp(8'd2, AccessAckData, 32'h0BAD_F00D, 0);
    tick();
    chk("t3_a_idle", h2d.a_valid, 0);
    chk("t3_r1_rdata", rdata, 32'h0BAD_F00D);
    chk("t3_r1_err", err, 0);
    d_resp(8'd3, AccessAck, 32'h0, 0);
    tick(); d_idle();
    chk("t3_r2_rvalid", rvalid, 1);
    chk("t3_r2_err", err, 0);

    // Outstanding limit of 4
    req = 1; we = 0;
    for (int i = 0; i < 4; i++) begin
      addr = 32'h5000_0000 + 32'(i * 4);
      #1 chk("t4_gnt", gnt, 1);
      tick();
      chk("t4_a_fields", a_obs(), a_exp(0, 32'h5000_0000 + 32'(i * 4), 0, 0, 8'(i)));
    end
    addr = 32'h5000_0010;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_gnt_full", gnt, 0);
      tick();
    end
    d_resp(8'd0, AccessAckData, 32'h1111_1111, 0);
    #1 chk("t4_no_same_cycle_credit", gnt, 0);
    tick(); d_idle();
    chk("t4_r0_rdata", rdata, 32'h1111_1111);
    #1 chk("t4_gnt_freed", gnt, 1);
    tick(); req = 0;
    chk("t4_fifth_a", a_obs(), a_exp(0, 32'h5000_0010, 0, 0, 8'd0));
    for (int i = 1; i <= 4; i++) begin
      d_resp(8'(i % 4), AccessAckData, 32'h2000 + 32'(i), 0);
      tick();
      chk("t4_drain_rdata", rdata, 32'h2000 + 32'(i));
      chk("t4_drain_err", err, 0);
    end
    d_idle();

    // Reset with 3 in flight and a_valid high
    req = 1; addr = 32'h5500_0000;
    repeat (3) tick();
    req = 0; d2h.a_ready = 0;
    #1 chk("t6_pre_a_valid", h2d.a_valid, 1);
    reset = 0;
    tick();
    reset = 1;
    chk("t6_a_valid", h2d.a_valid, 0);
    chk("t6_rvalid", rvalid, 0);
    req = 1; addr = 32'h6000_0000;
    #1 chk("t6_gnt", gnt, 1);
    tick(); req = 0;
    chk("t6_source0", a_obs(), a_exp(0, 32'h6000_0000, 0, 0, 8'd0));
    d2h.a_ready = 1;
    tick();

    // Errors: wrong source, d_error, wrong opcode, unexpected response
    d_resp(8'd2, AccessAckData, 32'h77, 0);
    tick(); d_idle();
    chk("t5_src_rvalid", rvalid, 1);
    chk("t5_src_err", err, 1);
    req = 1; tick(); req = 0; tick();
    d_resp(8'd1, AccessAckData, 32'h88, 1);
    tick(); d_idle();
    chk("t5_derr_err", err, 1);
    req = 1; tick(); req = 0; tick();
    d_resp(8'd2, AccessAck, 32'h0, 0);
    tick(); d_idle();
    chk("t5_opcode_err", err, 1);
    d_resp(8'd0, AccessAckData, 32'h99, 0);
    tick(); d_idle();
    chk("t5_unexp_rvalid", rvalid, 1);
    chk("t5_unexp_err", err, 1);
    chk("t5_unexp_rdata", rdata, 0);
    req = 1; addr = 32'h7000_0000;
    #1 chk("t5_unexp_gnt", gnt, 1);
    tick(); req = 0;
    chk("t5_after_src", a_obs(), a_exp(0, 32'h7000_0000, 0, 0, 8'd3));
    d_resp(8'd3, AccessAckData, 32'hCAFE, 0);
    tick(); d_idle();
    chk("t5_after_rdata", rdata, 32'hCAFE);
    chk("t5_after_err", err, 0);

    // Randomized run against the queue model
    reset = 0; tick(); reset = 1;
    out_cnt = 0; next_src = 0; g_s = 0; hsa_s = 0; hsd_s = 0; dd = '0; de = 0;
    for (int c = 0; c < 600; c++) begin
      hold = req && !g_s;
      if (!hold) begin
        req = ($urandom % 10) < 6; we = $urandom % 2; addr = $urandom;
        wdata = $urandom; be = 4'($urandom % 16);
      end
      d2h.a_ready = ($urandom % 4) != 0;
      if (devq.size() > 0 && ($urandom % 3) != 0) begin
        dd = $urandom; de = ($urandom % 8) == 0;
        d_resp(devq[0].src, devq[0].w ? AccessAck : AccessAckData, dd, de);
      end else begin
        d_idle();
      end
      #1;
      g_exp = req && (aq.size() == 0 || d2h.a_ready) && (out_cnt < 4);
      chk("rnd_gnt", gnt, g_exp);
      chk("rnd_a_valid", h2d.a_valid, aq.size() != 0);
      if (aq.size() != 0)
        chk("rnd_a_fields", a_obs(), a_exp(aq[0].w, aq[0].ad, aq[0].wd, aq[0].b, aq[0].src));
      g_s   = g_exp;
      hsa_s = (aq.size() != 0) && d2h.a_ready;
      hsd_s = d2h.d_valid;
      tick();
      if (hsd_s) begin
        t = devq.pop_front();
        out_cnt--;
        chk("rnd_rvalid", rvalid, 1);
        chk("rnd_rdata", rdata, t.w ? 32'd0 : dd);
        chk("rnd_err", err, de);
      end else begin
        chk("rnd_rvalid_idle", rvalid, 0);
      end
      if (hsa_s) devq.push_back(aq.pop_front());
      if (g_s) begin
        aq.push_back('{w: we, ad: addr, wd: wdata, b: be, src: next_src});
        next_src = (next_src + 8'd1) % 8'd4;
        out_cnt++;
      end
    end
    req = 0; d_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
